// File: rtl/mram_access_arbiter.sv
// -----------------------------------------------------------------------------
// mram_access_arbiter
//   Shares one asynchronous 16-bit MRAM port between two requesters and
//   sequences every access. Port 0 is the I2C slave bridge, port 1 the
//   on-chip test/scrub engine. Grants are round-robin. Each access runs
//   SETUP -> READ|WRITE -> TURN and ends with a one-cycle response pulse.
//
// Ports
//   FPGA_clk, FPGA_rst        clock, asynchronous active-high reset
//   req_valid/ready/we [1:0]  per-port request handshake and direction
//   req_addr/wdata/be         per-port packed request fields
//   rsp_valid [1:0]           per-port completion pulse
//   rsp_rdata                 last read data, held until the next read ends
//   write_addr, mem_dq_out,   MRAM address and write data, pad output enable
//   mem_dq_oe, mem_dq_in      and read data from the pad
//   chip_en, read_en,         MRAM E#, G#, W#, LB#, UB#, all active-low
//   write_en, lb_en, ub_en
// -----------------------------------------------------------------------------
module mram_access_arbiter #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int RD_CYC   = 4,
  parameter int WR_CYC   = 4,
  parameter int TURN_CYC = 1
) (
  input  logic                  FPGA_clk,
  input  logic                  FPGA_rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  input  logic [3:0]            req_be,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [ADDR_W-1:0]     write_addr,
  output logic [DATA_W-1:0]     mem_dq_out,
  output logic                  mem_dq_oe,
  input  logic [DATA_W-1:0]     mem_dq_in,
  output logic                  chip_en,
  output logic                  read_en,
  output logic                  write_en,
  output logic                  lb_en,
  output logic                  ub_en
);

  localparam int RW_MAX  = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int MAX_CYC = (RW_MAX > TURN_CYC) ? RW_MAX : TURN_CYC;
  localparam int PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [PH_W-1:0] RD_LAST   = PH_W'(RD_CYC - 1);
  localparam logic [PH_W-1:0] WR_LAST   = PH_W'(WR_CYC - 1);
  localparam logic [PH_W-1:0] TURN_LAST = PH_W'(TURN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_READ,
    S_WRITE,
    S_TURN
  } state_t;

  state_t              state;
  logic [PH_W-1:0]     phase;
  logic                last_grant;
  logic                gnt;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [1:0]          lat_be;

  logic                grant_port;
  logic [ADDR_W-1:0]   grant_addr;
  logic [DATA_W-1:0]   grant_wdata;
  logic [1:0]          grant_be;

  // With both ports requesting, the one not served last wins; otherwise the
  // single requester wins (bit 1 alone selects port 1, bit 0 alone port 0).
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    grant_port  = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    grant_addr  = grant_port ? req_addr[2*ADDR_W-1 -: ADDR_W]   : req_addr[ADDR_W-1:0];
    grant_wdata = grant_port ? req_wdata[2*DATA_W-1 -: DATA_W] : req_wdata[DATA_W-1:0];
    grant_be    = grant_port ? req_be[3:2]                     : req_be[1:0];
  end

  // Each state's outputs are registered on the edge that processes that
  // state, so they appear one cycle after the state is entered. The accept
  // cycle is therefore cycle 0, SETUP shows in cycle 1, the strobe in cycles
  // 2..1+N and the response in the first TURN cycle.
  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge FPGA_clk or posedge FPGA_rst) begin
    if (FPGA_rst) begin
      state      <= S_IDLE;
      phase      <= '0;
      last_grant <= 1'b1;      // port 0 is preferred first after reset
      gnt        <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      write_addr <= '0;
      mem_dq_out <= '0;
      mem_dq_oe  <= 1'b0;
      chip_en    <= 1'b1;
      read_en    <= 1'b1;
      write_en   <= 1'b1;
      lb_en      <= 1'b1;
      ub_en      <= 1'b1;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            req_ready[grant_port] <= 1'b1;
            gnt        <= grant_port;
            last_grant <= grant_port;
            lat_we     <= req_we[grant_port];
            lat_addr   <= grant_addr;
            lat_wdata  <= grant_wdata;
            lat_be     <= grant_be;
            phase      <= '0;
            state      <= S_SETUP;
          end
        end

        S_SETUP: begin
          phase <= '0;
          if (lat_be == 2'b00) begin
            // Nothing to transfer: complete without touching the bus.
            state <= S_TURN;
          end else begin
            write_addr <= lat_addr;
            chip_en    <= 1'b0;
            lb_en      <= ~lat_be[0];
            ub_en      <= ~lat_be[1];
            if (lat_we) begin
              mem_dq_oe  <= 1'b1;
              mem_dq_out <= lat_wdata;
              state      <= S_WRITE;
            end else begin
              state      <= S_READ;
            end
          end
        end

        S_READ: begin
          read_en <= 1'b0;
          if (phase == RD_LAST) begin
            phase <= '0;
            state <= S_TURN;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        S_WRITE: begin
          write_en  <= 1'b0;
          mem_dq_oe <= 1'b1;
          if (phase == WR_LAST) begin
            phase <= '0;
            state <= S_TURN;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        S_TURN: begin
          chip_en   <= 1'b1;
          read_en   <= 1'b1;
          write_en  <= 1'b1;
          lb_en     <= 1'b1;
          ub_en     <= 1'b1;
          mem_dq_oe <= 1'b0;
          if (phase == '0) begin
            rsp_valid[gnt] <= 1'b1;
            // This edge closes the last read_en-low cycle: sample the pad now.
            if (!lat_we && lat_be != 2'b00) rsp_rdata <= mem_dq_in;
          end
          if (phase == TURN_LAST) begin
            phase <= '0;
            state <= S_IDLE;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mram_access_arbiter.sv
module tb_mram_access_arbiter;

  localparam int ADDR_W   = 20;
  localparam int DATA_W   = 16;
  localparam int RD_CYC   = 4;
  localparam int WR_CYC   = 4;
  localparam int TURN_CYC = 1;

  logic                FPGA_clk = 1'b0;
  logic                FPGA_rst = 1'b1;
  logic [1:0]          req_valid = '0;
  logic [1:0]          req_ready;
  logic [1:0]          req_we = '0;
  logic [2*ADDR_W-1:0] req_addr = '0;
  logic [2*DATA_W-1:0] req_wdata = '0;
  logic [3:0]          req_be = '0;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic [ADDR_W-1:0]   write_addr;
  logic [DATA_W-1:0]   mem_dq_out;
  logic                mem_dq_oe;
  logic [DATA_W-1:0]   mem_dq_in;
  logic                chip_en, read_en, write_en, lb_en, ub_en;

  always #5 FPGA_clk = ~FPGA_clk;

  mram_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_CYC(RD_CYC), .WR_CYC(WR_CYC), .TURN_CYC(TURN_CYC)
  ) dut (
    .FPGA_clk(FPGA_clk), .FPGA_rst(FPGA_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .write_addr(write_addr), .mem_dq_out(mem_dq_out), .mem_dq_oe(mem_dq_oe),
    .mem_dq_in(mem_dq_in),
    .chip_en(chip_en), .read_en(read_en), .write_en(write_en), .lb_en(lb_en), .ub_en(ub_en)
  );

  function automatic logic [15:0] init_word(int i);
    return 16'(i * 4951) ^ 16'h2468;
  endfunction

  // Simple MRAM pad model: 16 words selected by the low address bits.
  logic [15:0] pad_mem [16];
  logic        dq_ovr_en  = 1'b0;
  logic [15:0] dq_ovr_val = '0;

  always @(posedge FPGA_clk) begin
    if (FPGA_rst) begin
      for (int i = 0; i < 16; i++) pad_mem[i] <= init_word(i);
    end else if (!chip_en && !write_en) begin
      if (!lb_en) pad_mem[write_addr[3:0]][7:0]  <= mem_dq_out[7:0];
      if (!ub_en) pad_mem[write_addr[3:0]][15:8] <= mem_dq_out[15:8];
    end
  end

  assign mem_dq_in = dq_ovr_en ? dq_ovr_val :
                     (!chip_en && !read_en) ? pad_mem[write_addr[3:0]] : 16'h0BAD;

  int total = 0;
  int bad   = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: one transaction record plus a timeline derived from it.
  int          cyc = 0;
  int          next_free = 0;
  int          cur_k = -1000;
  logic        cur_port = 1'b0;
  logic        cur_we = 1'b0;
  logic [1:0]  cur_be = '0;
  logic [19:0] cur_addr = '0;
  logic [15:0] cur_wdata = '0;
  logic [15:0] cur_rd_exp = '0;
  logic [15:0] exp_rdata = '0;
  logic        last_g = 1'b1;
  logic [15:0] ref_mem [16];

  int ce_lo, re_lo, we_lo, lb_lo, ub_lo, oe_hi, rsp_cyc;
  int gnt_cyc[$];
  int gnt_port[$];

  task automatic model_reset();
    cur_k     = -1000;
    next_free = 0;
    last_g    = 1'b1;
    exp_rdata = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic clear_counts();
    ce_lo = 0; re_lo = 0; we_lo = 0; lb_lo = 0; ub_lo = 0; oe_hi = 0; rsp_cyc = -1;
    gnt_cyc.delete();
    gnt_port.delete();
  endtask

  task automatic check_cycle();
    int         rel, n, len;
    logic       acc, in_win, st_win;
    logic [1:0] onehot;
    logic [5:0] exp_pins;
    rel    = cyc - cur_k;
    acc    = (cur_be != 2'b00);
    n      = cur_we ? WR_CYC : RD_CYC;
    len    = acc ? 2 + n : 2;
    onehot = cur_port ? 2'b10 : 2'b01;
    if (rel == len && acc && !cur_we) exp_rdata = cur_rd_exp;
    in_win = acc && rel >= 1 && rel <= 1 + n;
    st_win = acc && rel >= 2 && rel <= 1 + n;
    exp_pins = {~in_win, ~(st_win && !cur_we), ~(st_win && cur_we),
                ~(in_win && cur_be[0]), ~(in_win && cur_be[1]), in_win && cur_we};
    check("req_ready", 32'(req_ready), 32'((rel == 0) ? onehot : 2'b00));
    check("rsp_valid", 32'(rsp_valid), 32'((rel == len) ? onehot : 2'b00));
    check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
    check("pins", 32'({chip_en, read_en, write_en, lb_en, ub_en, mem_dq_oe}), 32'(exp_pins));
    if (in_win) check("write_addr", 32'(write_addr), 32'(cur_addr));
    if (in_win && cur_we) check("mem_dq_out", 32'(mem_dq_out), 32'(cur_wdata));
    check("rd_wr_excl", 32'(read_en | write_en), 32'd1);
    check("oe_vs_read", 32'(mem_dq_oe & ~read_en), 32'd0);
    if (!chip_en)  ce_lo++;
    if (!read_en)  re_lo++;
    if (!write_en) we_lo++;
    if (!lb_en)    lb_lo++;
    if (!ub_en)    ub_lo++;
    if (mem_dq_oe) oe_hi++;
    if (|rsp_valid) rsp_cyc = cyc;
    if (|req_ready) begin
      gnt_cyc.push_back(cyc);
      gnt_port.push_back(req_ready[1] ? 1 : 0);
    end
  endtask

  // One clock: the model decides at the edge, outputs are checked mid-cycle.
  task automatic cycle();
    logic g;
    int   n;
    @(posedge FPGA_clk);
    cyc++;
    if (cyc >= next_free && req_valid != 2'b00) begin
      g         = (req_valid == 2'b11) ? ~last_g : req_valid[1];
      last_g    = g;
      cur_k     = cyc;
      cur_port  = g;
      cur_we    = req_we[g];
      cur_addr  = g ? req_addr[39:20]  : req_addr[19:0];
      cur_wdata = g ? req_wdata[31:16] : req_wdata[15:0];
      cur_be    = g ? req_be[3:2]      : req_be[1:0];
      n         = cur_we ? WR_CYC : RD_CYC;
      next_free = cyc + ((cur_be != 2'b00) ? 2 + n : 2) + TURN_CYC;
      if (cur_we && cur_be[0]) ref_mem[cur_addr[3:0]][7:0]  = cur_wdata[7:0];
      if (cur_we && cur_be[1]) ref_mem[cur_addr[3:0]][15:8] = cur_wdata[15:8];
      cur_rd_exp = dq_ovr_en ? dq_ovr_val : ref_mem[cur_addr[3:0]];
    end
    @(negedge FPGA_clk);
    check_cycle();
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic set_port(int p, logic v, logic we, logic [19:0] a, logic [15:0] d, logic [1:0] be);
    req_valid[p]         = v;
    req_we[p]            = we;
    req_addr[p*20 +: 20] = a;
    req_wdata[p*16 +: 16] = d;
    req_be[p*2 +: 2]     = be;
  endtask

  task automatic issue(int p, logic we, logic [19:0] a, logic [15:0] d, logic [1:0] be);
    set_port(p, 1'b1, we, a, d, be);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (req_ready[p]) break;
    end
    check("issue_accept", 32'(req_ready[p]), 32'd1);
    req_valid[p] = 1'b0;
  endtask

  initial begin
    int          k0;
    logic [15:0] tmp;

    model_reset();
    repeat (2) @(posedge FPGA_clk);
    @(negedge FPGA_clk);
    check("rst_pins", 32'({chip_en, read_en, write_en, lb_en, ub_en, mem_dq_oe}), 32'h3E);
    check("rst_handshake", 32'({req_ready, rsp_valid}), 32'd0);
    check("rst_data", 32'(write_addr | mem_dq_out | rsp_rdata), 32'd0);
    FPGA_rst = 1'b0;

    // Port 0 full-word write.
    clear_counts();
    issue(0, 1'b1, 20'h00012, 16'hA5C3, 2'b11);
    k0 = cyc;
    run(8);
    check("wr_ce_cycles", 32'(ce_lo), 32'd5);
    check("wr_we_cycles", 32'(we_lo), 32'd4);
    check("wr_lanes", 32'({lb_lo, ub_lo} == {32'd5, 32'd5}), 32'd1);
    check("wr_rsp_latency", 32'(rsp_cyc - k0), 32'd6);

    // Port 1 read at the top address with a forced pad value.
    dq_ovr_en  = 1'b1;
    dq_ovr_val = 16'h5555;
    clear_counts();
    issue(1, 1'b0, 20'hFFFFF, 16'h0000, 2'b11);
    k0 = cyc;
    run(8);
    dq_ovr_en = 1'b0;
    check("rd_re_cycles", 32'(re_lo), 32'd4);
    check("rd_oe_never", 32'(oe_hi), 32'd0);
    check("rd_rsp_latency", 32'(rsp_cyc - k0), 32'd6);
    check("rd_data", 32'(rsp_rdata), 32'h5555);

    // Both ports requesting continuously.
    clear_counts();
    set_port(0, 1'b1, 1'b0, 20'h00001, 16'h0, 2'b11);
    set_port(1, 1'b1, 1'b0, 20'h00003, 16'h0, 2'b11);
    run(30);
    req_valid = 2'b00;
    run(8);
    check("rr_grant_count", 32'(gnt_port.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_port.size()) check("rr_grant_port", 32'(gnt_port[i]), 32'(i % 2));
      if (i + 1 < gnt_cyc.size()) check("rr_grant_gap", 32'(gnt_cyc[i+1] - gnt_cyc[i]), 32'd7);
    end

    // Low-byte-only write, then an empty byte-enable write, then read back.
    clear_counts();
    issue(0, 1'b1, 20'h00005, 16'h1234, 2'b01);
    k0 = cyc;
    run(8);
    check("be01_lb_cycles", 32'(lb_lo), 32'd5);
    check("be01_ub_cycles", 32'(ub_lo), 32'd0);
    check("be01_rsp_latency", 32'(rsp_cyc - k0), 32'd6);
    clear_counts();
    issue(0, 1'b1, 20'h00006, 16'hFFFF, 2'b00);
    k0 = cyc;
    run(4);
    check("be00_no_strobe", 32'(ce_lo + oe_hi), 32'd0);
    check("be00_rsp_latency", 32'(rsp_cyc - k0), 32'd2);
    issue(0, 1'b0, 20'h00005, 16'h0, 2'b11);
    run(8);
    tmp = init_word(5);
    check("be01_readback", 32'(rsp_rdata), 32'({tmp[15:8], 8'h34}));
    issue(1, 1'b0, 20'h00006, 16'h0, 2'b11);
    run(8);
    check("be00_readback", 32'(rsp_rdata), 32'(init_word(6)));

    // Reset in the middle of a write.
    issue(0, 1'b1, 20'h00007, 16'hBEEF, 2'b11);
    run(3);
    check("pre_rst_write_low", 32'(write_en), 32'd0);
    req_valid = 2'b00;
    FPGA_rst = 1'b1;
    #1;
    check("midrst_strobes", 32'({chip_en, read_en, write_en, lb_en, ub_en}), 32'h1F);
    check("midrst_oe", 32'(mem_dq_oe), 32'd0);
    check("midrst_rsp", 32'(rsp_valid), 32'd0);
    @(posedge FPGA_clk);
    cyc++;
    @(negedge FPGA_clk);
    FPGA_rst = 1'b0;
    model_reset();
    check("post_rst_rdata", 32'(rsp_rdata), 32'd0);
    set_port(0, 1'b1, 1'b0, 20'h00000, 16'h0, 2'b11);
    set_port(1, 1'b1, 1'b0, 20'h00001, 16'h0, 2'b11);
    cycle();
    check("post_rst_grant", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    run(8);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      for (int p = 0; p < 2; p++) begin
        set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 20'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(0, 3)));
      end
      cycle();
    end
    req_valid = 2'b00;
    run(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
